raw10_depacker: RTL and testbench

//  Converts the 16-bit CSI payload stream (out_stream/frame_valid/frame_active) into RAW10 pixels.

---
 rtl/csi_pkg.sv | 21 ++
 rtl/raw10_unpack4.sv | 18 +
 rtl/raw10_depacker.sv | 180 ++++++++++++++++++
 tb/tb_raw10_depacker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared CSI receive definitions: RAW10 constants, depacker FSM states and a
// saturating counter helper.
package csi_pkg;

    localparam logic [5:0] DT_RAW10        = 6'h2B;
    localparam int         BYTES_PER_GROUP = 5;
    localparam int         PIX_PER_GROUP   = 4;
    localparam int         PIX_W           = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } depack_state_e;

    // Pixel count grows by one group at a time and sticks at all-ones.
    function automatic logic [15:0] sat_add_group(input logic [15:0] value);
        return (value > 16'hFFFB) ? 16'hFFFF : value + 16'd4;
    endfunction

endpackage

// File: rtl/raw10_unpack4.sv
// Combinational RAW10 unpacker: bytes b0..b4 (b0 in [7:0]) -> {p3,p2,p1,p0}.
// Each pixel takes its upper 8 bits from bk and its 2 LSBs from b4.
module raw10_unpack4
    import csi_pkg::*;
(
    input  logic [8*BYTES_PER_GROUP-1:0]     bytes_in,
    output logic [PIX_PER_GROUP*PIX_W-1:0]   pix_out
);

    // Slice the four MSB bytes and the shared LSB byte into pixels.
    always_comb begin
        pix_out = '0;
        for (int k = 0; k < PIX_PER_GROUP; k++) begin
            pix_out[k*PIX_W +: PIX_W] = {bytes_in[k*8 +: 8], bytes_in[32 + 2*k +: 2]};
        end
    end

endmodule

// File: rtl/raw10_depacker.sv
// RAW10 depacker: turns the 16-bit CSI payload stream into 4-pixel groups
// with line/frame markers, line numbering and per-line error flags.
module raw10_depacker
    import csi_pkg::*;
#(
    parameter int unsigned EXP_PIXELS = 32'd0
) (
    input  logic        rxbyteclkhs,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        frame_active,
    output logic [39:0] pix_data,
    output logic        pix_valid,
    output logic        line_start,
    output logic        line_end,
    output logic        frame_start,
    output logic        frame_end,
    output logic [15:0] line_idx,
    output logic        err_partial,
    output logic        err_len
);

    localparam bit          LEN_CHECK = (EXP_PIXELS != 32'd0);
    localparam logic [15:0] EXP_W     = 16'(EXP_PIXELS);

    depack_state_e state_r, state_next_s;

    logic [31:0] buf_r;          // up to 4 held bytes, oldest in [7:0]
    logic [2:0]  cnt_r;
    logic [15:0] pix_cnt_r;
    logic [15:0] line_cnt_r;
    logic        first_r;

    logic [47:0] ext_s;
    logic [2:0]  total_s;
    logic [2:0]  rem_s;
    logic        consume_s;
    logic        emit_s;
    logic        end_line_s;
    logic        fs_s;
    logic        fe_s;
    logic [15:0] pix_cnt_next_s;
    logic [39:0] group_s;

    // Next-state and per-cycle action decode.
    always_comb begin
        state_next_s = state_r;
        consume_s    = 1'b0;
        end_line_s   = 1'b0;
        fs_s         = 1'b0;
        fe_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_active) begin
                    state_next_s = ST_FRAME;
                    fs_s         = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (!frame_active) begin
                    state_next_s = ST_IDLE;
                    fe_s         = 1'b1;
                end else if (in_valid) begin
                    state_next_s = ST_LINE;
                    consume_s    = 1'b1;
                end else begin
                    state_next_s = ST_FRAME;
                end
            end
            ST_LINE: begin
                consume_s = in_valid;
                // A frame_active drop closes the line now; FRAME then issues frame_end.
                if (!in_valid || !frame_active) begin
                    state_next_s = ST_FRAME;
                    end_line_s   = 1'b1;
                end else begin
                    state_next_s = ST_LINE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Append the incoming byte pair behind the held bytes.
    always_comb begin
        ext_s = '0;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) < cnt_r) begin
                ext_s[8*i +: 8] = buf_r[8*(i % 4) +: 8];
            end else if (3'(i) == cnt_r) begin
                ext_s[8*i +: 8] = in_data[7:0];
            end else if (3'(i) == cnt_r + 3'd1) begin
                ext_s[8*i +: 8] = in_data[15:8];
            end else begin
                ext_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Group completion and the counts that result from this cycle.
    always_comb begin
        total_s = cnt_r + 3'd2;
        emit_s  = consume_s && (total_s >= 3'd5);
        if (!consume_s) begin
            rem_s = cnt_r;
        end else if (emit_s) begin
            rem_s = total_s - 3'd5;
        end else begin
            rem_s = total_s;
        end
        if (emit_s) begin
            pix_cnt_next_s = sat_add_group(pix_cnt_r);
        end else begin
            pix_cnt_next_s = pix_cnt_r;
        end
    end

    raw10_unpack4 u_unpack (
        .bytes_in (ext_s[39:0]),
        .pix_out  (group_s)
    );

    // State, buffer, counters and registered outputs.
    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            buf_r       <= 32'h0;
            cnt_r       <= 3'd0;
            pix_cnt_r   <= 16'd0;
            line_cnt_r  <= 16'd0;
            first_r     <= 1'b1;
            pix_data    <= 40'h0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_idx    <= 16'd0;
            err_partial <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pix_valid   <= emit_s;
            line_start  <= emit_s && first_r;
            line_end    <= end_line_s;
            frame_start <= fs_s;
            frame_end   <= fe_s;
            err_partial <= end_line_s && (rem_s != 3'd0);
            err_len     <= end_line_s && LEN_CHECK && (pix_cnt_next_s != EXP_W);
            if (emit_s) begin
                pix_data <= group_s;
                line_idx <= line_cnt_r;
            end
            if (end_line_s) begin
                cnt_r <= 3'd0;
            end else if (consume_s) begin
                cnt_r <= rem_s;
                buf_r <= emit_s ? {24'h0, ext_s[47:40]} : ext_s[31:0];
            end
            if (end_line_s) begin
                pix_cnt_r <= 16'd0;
                first_r   <= 1'b1;
            end else if (emit_s) begin
                pix_cnt_r <= pix_cnt_next_s;
                first_r   <= 1'b0;
            end
            if (fs_s) begin
                line_cnt_r <= 16'd0;
            end else if (end_line_s) begin
                line_cnt_r <= line_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_raw10_depacker.sv
// Self-checking bench for raw10_depacker: a byte-queue reference model checked
// every cycle, directed scenarios pinned to literals, then random frames.
module tb_raw10_depacker;

    localparam int EXP = 8;

    logic        rxbyteclkhs = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        frame_active;
    logic [39:0] pix_data;
    logic        pix_valid, line_start, line_end, frame_start, frame_end;
    logic [15:0] line_idx;
    logic        err_partial, err_len;

    always #5 rxbyteclkhs = ~rxbyteclkhs;

    raw10_depacker #(.EXP_PIXELS(EXP)) dut (
        .rxbyteclkhs  (rxbyteclkhs),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .frame_active (frame_active),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .line_start   (line_start),
        .line_end     (line_end),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .line_idx     (line_idx),
        .err_partial  (err_partial),
        .err_len      (err_len)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_BETWEEN, M_IN} mmode_t;
    mmode_t      mmode;
    int          mq[$];
    int          mpix, midx, step;
    bit          mfirst;
    logic [39:0] e_pd;
    logic [15:0] e_idx;
    bit          e_pv, e_ls, e_le, e_fs, e_fe, e_ep, e_el;

    logic [39:0] log_grp[$];
    int          log_gidx[$];
    bit          log_ls[$];
    bit          log_ep[$];
    bit          log_el[$];
    int          le_step, fe_step, fall_step;

    task automatic clear_logs();
        log_grp.delete(); log_gidx.delete(); log_ls.delete();
        log_ep.delete(); log_el.delete();
        le_step = -1; fe_step = -1; fall_step = -1;
    endtask

    task automatic m_consume(input logic [15:0] w);
        int b[5];
        logic [39:0] g;
        mq.push_back(int'(w[7:0]));
        mq.push_back(int'(w[15:8]));
        if (mq.size() >= 5) begin
            for (int k = 0; k < 5; k++) b[k] = mq.pop_front();
            g = '0;
            for (int k = 0; k < 4; k++)
                g = g | (40'(b[k] * 4 + ((b[4] >> (2 * k)) & 3)) << (10 * k));
            e_pd  = g;
            e_pv  = 1'b1;
            e_ls  = mfirst;
            e_idx = 16'(midx);
            mfirst = 1'b0;
            mpix = (mpix + 4 > 65535) ? 65535 : mpix + 4;
            log_grp.push_back(g);
            log_gidx.push_back(midx);
            log_ls.push_back(e_ls);
        end
    endtask

    task automatic m_endline();
        e_le = 1'b1;
        e_ep = (mq.size() != 0);
        e_el = (EXP != 0) && (mpix != EXP);
        log_ep.push_back(e_ep);
        log_el.push_back(e_el);
        le_step = step;
        mq.delete();
        mpix = 0;
        midx = (midx + 1) % 65536;
        mfirst = 1'b1;
    endtask

    // Model advances on each rising edge from the sampled inputs.
    initial begin
        mmode = M_OFF; mfirst = 1'b1; mpix = 0; midx = 0; step = 0;
        e_pd = '0; e_idx = '0;
        forever begin
            @(posedge rxbyteclkhs);
            step++;
            {e_pv, e_ls, e_le, e_fs, e_fe, e_ep, e_el} = 7'b0;
            if (reset) begin
                mmode = M_OFF; mq.delete(); mpix = 0; midx = 0; mfirst = 1'b1;
            end else if (mmode == M_OFF) begin
                if (frame_active) begin
                    e_fs = 1'b1; midx = 0; mmode = M_BETWEEN;
                end
            end else if (mmode == M_BETWEEN) begin
                if (!frame_active) begin
                    e_fe = 1'b1; fe_step = step; mmode = M_OFF;
                end else if (in_valid) begin
                    m_consume(in_data); mmode = M_IN;
                end
            end else begin
                if (in_valid) m_consume(in_data);
                if (in_valid && !frame_active) fall_step = step;
                if (!in_valid || !frame_active) begin
                    m_endline(); mmode = M_BETWEEN;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge rxbyteclkhs);
            chk("pix_valid",   pix_valid,   e_pv);
            chk("line_start",  line_start,  e_ls);
            chk("line_end",    line_end,    e_le);
            chk("frame_start", frame_start, e_fs);
            chk("frame_end",   frame_end,   e_fe);
            chk("err_partial", err_partial, e_ep);
            chk("err_len",     err_len,     e_el);
            if (e_pv) begin
                chk("pix_data", pix_data, e_pd);
                chk("line_idx", line_idx, e_idx);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] wq[$];

    task automatic drive(input bit iv, input bit fa, input logic [15:0] d);
        @(negedge rxbyteclkhs);
        reset = 1'b0; in_valid = iv; frame_active = fa; in_data = d;
    endtask

    task automatic idle(input int n, input bit fa);
        for (int i = 0; i < n; i++) drive(1'b0, fa, 16'(i * 16'h1357));
    endtask

    // Sends wq as one line; the last word optionally carries the frame_active drop.
    task automatic send_line(input bit fall_on_last);
        for (int i = 0; i < wq.size(); i++)
            drive(1'b1, !(fall_on_last && i == wq.size() - 1), wq[i]);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
    endtask

    localparam logic [39:0] G1 = {10'h010, 10'h00C, 10'h009, 10'h005};
    localparam logic [39:0] G2 = {10'h024, 10'h020, 10'h01E, 10'h01A};

    initial begin
        reset = 1'b1; in_valid = 1'b0; frame_active = 1'b0; in_data = 16'h0;
        clear_logs();
        repeat (3) @(negedge rxbyteclkhs);
        chk("reset_pix_data", pix_data, 40'h0);
        chk("reset_line_idx", line_idx, 16'h0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Test 1: reference words
        clear_logs();
        wq = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09};
        send_line(1'b0);
        idle(3, 1'b1);
        chk("t1_groups", log_grp.size(), 2);
        chk("t1_g0", log_grp[0], G1);
        chk("t1_g1", log_grp[1], G2);
        chk("t1_ls0", log_ls[0], 1'b1);
        chk("t1_ls1", log_ls[1], 1'b0);

        // Test 2: LSB byte extremes
        clear_logs();
        wq = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFF00};
        send_line(1'b0);
        idle(2, 1'b1);
        chk("t2_g0", log_grp[0], {4{10'h3FC}});
        chk("t2_g1", log_grp[1], {4{10'h003}});

        // Test 3: 12-byte line leaves 2 bytes; next line restarts cleanly
        clear_logs();
        rand_words(6);
        send_line(1'b0);
        idle(2, 1'b1);
        chk("t3_groups", log_grp.size(), 2);
        chk("t3_partial", log_ep[0], 1'b1);
        chk("t3_len", log_el[0], 1'b0);
        wq = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09};
        send_line(1'b0);
        idle(2, 1'b1);
        chk("t3_restart", log_grp[2], G1);

        // Test 4: length check and line numbering over a fresh frame
        idle(3, 1'b0);
        clear_logs();
        idle(2, 1'b1);
        rand_words(5);  send_line(1'b0); idle(2, 1'b1);
        rand_words(10); send_line(1'b0); idle(2, 1'b1);
        rand_words(5);  send_line(1'b0); idle(2, 1'b1);
        chk("t4_len_ok",  log_el[0], 1'b0);
        chk("t4_len_bad", log_el[1], 1'b1);
        chk("t4_idx0", log_gidx[0], 0);
        chk("t4_idx1", log_gidx[2], 1);
        chk("t4_idx2", log_gidx[6], 2);
        idle(3, 1'b0);
        idle(2, 1'b1);
        rand_words(5);  send_line(1'b0); idle(2, 1'b1);
        chk("t4_idx_new_frame", log_gidx[8], 0);

        // Test 5: frame_active falls with the last word, then IDLE pulses
        clear_logs();
        rand_words(4);
        send_line(1'b1);
        idle(3, 1'b0);
        chk("t5_consumed", log_grp.size(), 1);
        chk("t5_le_with_fall", le_step, fall_step);
        chk("t5_fe_after_le", fe_step, le_step + 1);
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'($urandom));
            drive(1'b0, 1'b0, 16'h0);
        end
        chk("t5_idle_no_groups", log_grp.size(), 0);

        // Test 6: reset mid-line
        idle(2, 1'b1);
        rand_words(3);
        send_line(1'b0);
        @(negedge rxbyteclkhs);
        reset = 1'b1; in_valid = 1'b0; frame_active = 1'b0;
        clear_logs();
        @(negedge rxbyteclkhs);
        chk("t6_pix_data", pix_data, 40'h0);
        chk("t6_line_idx", line_idx, 16'h0);
        idle(2, 1'b0);
        chk("t6_no_line_end", log_ep.size(), 0);
        idle(2, 1'b1);
        rand_words(5); send_line(1'b0); idle(2, 1'b1);
        chk("t6_groups", log_grp.size(), 2);
        chk("t6_line_ends", log_ep.size(), 1);
        idle(3, 1'b0);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            idle($urandom_range(3, 1), 1'b1);
            for (int l = 0; l < $urandom_range(6, 1); l++) begin
                rand_words($urandom_range(12, 1));
                if ($urandom_range(9, 0) < 2) begin
                    send_line(1'b1);
                    break;
                end
                send_line(1'b0);
                idle($urandom_range(3, 1), 1'b1);
            end
            idle($urandom_range(3, 2), 1'b0);
            if ($urandom_range(1, 0) == 1) begin
                drive(1'b1, 1'b0, 16'($urandom));
                idle(1, 1'b0);
            end
        end
        idle(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
